// File: rtl/alu_div_pkg.sv
// ---------------------------------------------------------------------------
// alu_div_pkg
// Shared definitions for the iterative divider in the multdiv unit.
//   div_state_t : divider FSM states (IDLE, ITER, FIX)
//   DIV_WIDTH   : operand / quotient width in bits
//   CNT_WIDTH   : width of the iteration counter, wide enough to hold DIV_WIDTH
// ---------------------------------------------------------------------------
package alu_div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_WIDTH = $clog2(DIV_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } div_state_t;

endpackage

// File: rtl/alu_divider_div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor and keep the
// difference only when it did not go negative.
// Ports:
//   r_in  [WIDTH:0]   partial remainder before the step
//   q_in  [WIDTH-1:0] quotient shift register before the step
//   d_in  [WIDTH-1:0] divisor magnitude
//   r_out [WIDTH:0]   partial remainder after the step
//   q_out [WIDTH-1:0] quotient shift register after the step
// ---------------------------------------------------------------------------
module div_step
  import alu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   r_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH:0]   r_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH:0] r_shift;
  logic [WIDTH:0] trial;
  logic           borrow;

  // The remainder never reaches the divisor, so its top bit is always zero
  // and only the lower WIDTH bits take part in the shift.
  logic unused_r_msb;
  assign unused_r_msb = r_in[WIDTH];

  assign r_shift = {r_in[WIDTH-1:0], q_in[WIDTH-1]};

  // Subtraction built as an adder with the divisor inverted and carry-in of one.
  assign trial  = r_shift + ~{1'b0, d_in} + {{WIDTH{1'b0}}, 1'b1};

  // A set top bit means the trial went negative: restore the shifted remainder.
  assign borrow = trial[WIDTH];
  assign r_out  = borrow ? r_shift : trial;
  assign q_out  = {q_in[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/alu_divider.sv
// ---------------------------------------------------------------------------
// alu_divider
// Iterative integer divider: one quotient bit per clock by restoring
// division, then an optional sign fix. Divide-by-zero and the signed
// overflow case are resolved at the start edge without iterating.
// Ports:
//   clock           rising-edge clock
//   reset           synchronous, active-high reset
//   ctrl_div        start pulse, only honoured while idle
//   data_operandA   dividend, sampled on the start edge
//   data_operandB   divisor, sampled on the start edge
//   data_result     quotient, held until the next published result or reset
//   data_exception  divide-by-zero / signed overflow, valid with data_result
//   data_resultRDY  one-cycle pulse marking data_result/data_exception valid
// Build option:
//   DIV_SIGNED_EN   defined   -> two's complement operands, sign fix and
//                                overflow detection are built
//                   undefined -> unsigned operands, no negation logic
// ---------------------------------------------------------------------------
module alu_divider
  import alu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(WIDTH - 1);
  localparam logic [WIDTH-1:0]     MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t           state;
  logic [CNT_WIDTH-1:0] count;
  logic [WIDTH:0]       r;
  logic [WIDTH-1:0]     q;
  logic [WIDTH-1:0]     d;
  logic                 exc_pending;

  logic [WIDTH:0]       r_next;
  logic [WIDTH-1:0]     q_next;
  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic                 start_sign;
  logic                 overflow;
  logic                 div_zero;
  logic [WIDTH-1:0]     fixed_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_in  (r),
    .q_in  (q),
    .d_in  (d),
    .r_out (r_next),
    .q_out (q_next)
  );

  assign div_zero = (data_operandB == '0);

`ifdef DIV_SIGNED_EN
  logic sign;

  // Magnitudes of the operands; the most negative value maps onto the
  // unsigned 2^(WIDTH-1), which the unsigned core handles correctly.
  assign abs_a      = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
  assign abs_b      = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;
  assign start_sign = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
  assign overflow   = (data_operandA == MOST_NEG) && (data_operandB == '1);
  assign fixed_q    = sign ? (~q + WIDTH'(1)) : q;
`else
  assign abs_a      = data_operandA;
  assign abs_b      = data_operandB;
  assign start_sign = 1'b0;
  assign overflow   = 1'b0;
  assign fixed_q    = q;

  logic unused_sign;
  assign unused_sign = start_sign;
`endif

  // Divider FSM. Exceptional starts preload Q with the value to publish and
  // jump straight to FIX, so the result path is shared with normal division.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      count          <= '0;
      r              <= '0;
      q              <= '0;
      d              <= '0;
      exc_pending    <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
`ifdef DIV_SIGNED_EN
      sign           <= 1'b0;
`endif
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        IDLE: begin
          if (ctrl_div) begin
            r     <= '0;
            count <= '0;
            d     <= abs_b;
            if (div_zero) begin
              q           <= '0;
              exc_pending <= 1'b1;
              state       <= FIX;
`ifdef DIV_SIGNED_EN
              sign        <= 1'b0;
`endif
            end else if (overflow) begin
              q           <= MOST_NEG;
              exc_pending <= 1'b1;
              state       <= FIX;
`ifdef DIV_SIGNED_EN
              sign        <= 1'b0;
`endif
            end else begin
              q           <= abs_a;
              exc_pending <= 1'b0;
              state       <= ITER;
`ifdef DIV_SIGNED_EN
              sign        <= start_sign;
`endif
            end
          end
        end
        ITER: begin
          r     <= r_next;
          q     <= q_next;
          count <= count + CNT_WIDTH'(1);
          if (count == LAST_STEP) begin
            state <= FIX;
          end
        end
        FIX: begin
          data_result    <= fixed_q;
          data_exception <= exc_pending;
          data_resultRDY <= 1'b1;
          state          <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_divider.sv
// ---------------------------------------------------------------------------
// tb_alu_divider
// Directed self-checking bench for alu_divider. Expected values are hand
// computed; the signed or unsigned set is chosen by DIV_SIGNED_EN so the
// bench matches whichever build it is compiled against.
// ---------------------------------------------------------------------------
module tb_alu_divider;
  import alu_div_pkg::*;

  localparam int W = DIV_WIDTH;

  logic         clock = 1'b0;
  logic         reset;
  logic         ctrl_div;
  logic [W-1:0] data_operandA;
  logic [W-1:0] data_operandB;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_resultRDY;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  alu_divider #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_div       (ctrl_div),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  // Present a one-cycle start pulse; returns #1 after the start edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    ctrl_div      = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_div = 1'b0;
  endtask

  // Count edges until the ready pulse appears, bounded at 100 edges.
  task automatic waitReady(output int edges);
    edges = 0;
    while (data_resultRDY !== 1'b1 && edges < 100) begin
      @(posedge clock);
      #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    ctrl_div = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    checks++;
    if (data_result !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_result: got %h expected %h", data_result, 32'h0);
    end
    checks++;
    if (data_exception !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_exception: got %b expected 0", data_exception);
    end
    checks++;
    if (data_resultRDY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %b expected 0", data_resultRDY);
    end
  endtask

  task automatic test_sign_fix();
    int edges;
    logic [W-1:0] exp_q;
`ifdef DIV_SIGNED_EN
    exp_q = 32'hFFFF_FFFD;
`else
    exp_q = 32'h0000_0000;
`endif
    applyStimulus(32'd6, 32'hFFFF_FFFE);
    waitReady(edges);
    checks++;
    if (edges !== 33) begin
      errors++;
      $display("[TB] FAIL sign_latency: got %0d edges expected 33", edges);
    end
    checks++;
    if (data_result !== exp_q) begin
      errors++;
      $display("[TB] FAIL sign_result: got %h expected %h", data_result, exp_q);
    end
    checks++;
    if (data_exception !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sign_exception: got %b expected 0", data_exception);
    end
    @(posedge clock);
    #1;
    checks++;
    if (data_resultRDY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_width: got %b expected 0 one cycle after pulse", data_resultRDY);
    end
    checks++;
    if (data_result !== exp_q) begin
      errors++;
      $display("[TB] FAIL result_hold: got %h expected %h", data_result, exp_q);
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    logic [W-1:0] exp_q2;
`ifdef DIV_SIGNED_EN
    exp_q2 = 32'hFFFF_FFF2;
`else
    exp_q2 = 32'h2492_4916;
`endif
    applyStimulus(32'd100, 32'd7);
    waitReady(edges);
    checks++;
    if (edges !== 33) begin
      errors++;
      $display("[TB] FAIL b2b_first_latency: got %0d edges expected 33", edges);
    end
    checks++;
    if (data_result !== 32'd14) begin
      errors++;
      $display("[TB] FAIL b2b_first_result: got %h expected %h", data_result, 32'd14);
    end
    // Issue the next start while the ready pulse is still high.
    applyStimulus(32'hFFFF_FF9C, 32'd7);
    waitReady(edges);
    checks++;
    if (edges !== 33) begin
      errors++;
      $display("[TB] FAIL b2b_second_latency: got %0d edges expected 33", edges);
    end
    checks++;
    if (data_result !== exp_q2) begin
      errors++;
      $display("[TB] FAIL b2b_second_result: got %h expected %h", data_result, exp_q2);
    end
    checks++;
    if (data_exception !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_second_exception: got %b expected 0", data_exception);
    end
  endtask

  task automatic test_div_zero();
    int edges;
    applyStimulus(32'd5, 32'd0);
    waitReady(edges);
    checks++;
    if (edges !== 1) begin
      errors++;
      $display("[TB] FAIL divzero_latency: got %0d edges expected 1", edges);
    end
    checks++;
    if (data_result !== 32'h0) begin
      errors++;
      $display("[TB] FAIL divzero_result: got %h expected %h", data_result, 32'h0);
    end
    checks++;
    if (data_exception !== 1'b1) begin
      errors++;
      $display("[TB] FAIL divzero_exception: got %b expected 1", data_exception);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_overflow();
    int edges;
    int exp_edges;
    logic [W-1:0] exp_q;
    logic exp_exc;
`ifdef DIV_SIGNED_EN
    exp_edges = 1;
    exp_q     = 32'h8000_0000;
    exp_exc   = 1'b1;
`else
    exp_edges = 33;
    exp_q     = 32'h0000_0000;
    exp_exc   = 1'b0;
`endif
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF);
    waitReady(edges);
    checks++;
    if (edges !== exp_edges) begin
      errors++;
      $display("[TB] FAIL ovf_latency: got %0d edges expected %0d", edges, exp_edges);
    end
    checks++;
    if (data_result !== exp_q) begin
      errors++;
      $display("[TB] FAIL ovf_result: got %h expected %h", data_result, exp_q);
    end
    checks++;
    if (data_exception !== exp_exc) begin
      errors++;
      $display("[TB] FAIL ovf_exception: got %b expected %b", data_exception, exp_exc);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset_mid();
    int edges;
    int pulses;
    applyStimulus(32'd1000, 32'd3);
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    checks++;
    if (data_result !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midreset_result: got %h expected %h", data_result, 32'h0);
    end
    checks++;
    if (data_exception !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_exception: got %b expected 0", data_exception);
    end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("[TB] FAIL midreset_pulses: got %0d ready pulses expected 0", pulses);
    end
    applyStimulus(32'd9, 32'd3);
    waitReady(edges);
    checks++;
    if (edges !== 33) begin
      errors++;
      $display("[TB] FAIL after_reset_latency: got %0d edges expected 33", edges);
    end
    checks++;
    if (data_result !== 32'd3) begin
      errors++;
      $display("[TB] FAIL after_reset_result: got %h expected %h", data_result, 32'd3);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_ignore_start();
    int pulses;
    int first_edge;
    logic [W-1:0] got_q;
    logic [W-1:0] exp_q;
`ifdef DIV_SIGNED_EN
    exp_q = 32'hFFFF_FFFF;
`else
    exp_q = 32'h7FFF_FFFF;
`endif
    pulses     = 0;
    first_edge = 0;
    got_q      = '0;
    applyStimulus(32'hFFFF_FFFE, 32'd2);
    for (int i = 1; i <= 80; i++) begin
      if (i == 5) begin
        ctrl_div      = 1'b1;
        data_operandA = 32'd10;
        data_operandB = 32'd5;
      end
      @(posedge clock);
      #1;
      ctrl_div = 1'b0;
      if (data_resultRDY === 1'b1) begin
        pulses++;
        if (first_edge == 0) begin
          first_edge = i;
          got_q      = data_result;
        end
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("[TB] FAIL ignore_pulses: got %0d ready pulses expected 1", pulses);
    end
    checks++;
    if (first_edge !== 33) begin
      errors++;
      $display("[TB] FAIL ignore_latency: got %0d edges expected 33", first_edge);
    end
    checks++;
    if (got_q !== exp_q) begin
      errors++;
      $display("[TB] FAIL ignore_result: got %h expected %h", got_q, exp_q);
    end
  endtask

  initial begin
    test_reset();
    test_sign_fix();
    test_back_to_back();
    test_div_zero();
    test_overflow();
    test_reset_mid();
    test_ignore_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
